control_register_bank: RTL
==========================

// Module: control_register_bank
// PURPOSE
//  Multi-register successor to the single-byte control decoder. Parses the byte stream from the
//  transfer-in receiver for framed writes: H1 H2 H3 ADDR DATA CHK. Updates one of N_REGS 8-bit
//  control registers per frame. Adds checksum, address range check, inter-byte timeout and
//  error reporting. Sits between the transfer-in receiver and the collector's mode/config logic.
// PARAMETERS
//  N_REGS          4       number of 8-bit control registers (1..255)
//  HDR_BYTE1       8'h5A   first header byte
//  HDR_BYTE2       8'hC3   second header byte
//  HDR_BYTE3       8'h7E   third header byte
//  REG_RESET       0       reset value loaded into every control register (8 bits)
//  TIMEOUT_CYCLES  1000    CLK cycles allowed between bytes inside a frame; 0 = timeout disabled
// PORTS
//  CLK                   in   1         system clock, rising edge
//  RST                   in   1         reset, asynchronous, active-low
//  TRANSFER_IN_RECEIVED  in   1         byte-valid level from receiver; one byte per rising edge
//  TRANSFER_IN_BYTE      in   8         received byte, stable while TRANSFER_IN_RECEIVED high
//  CONTROL_REGS          out  8*N_REGS  register k at bits [8k+7:8k]
//  REG_UPDATE            out  1         1-cycle pulse: a register was written
//  UPDATE_ADDR           out  8         address of last successful write (held)
//  FRAME_ERROR           out  1         1-cycle pulse: checksum, address or timeout error
//  ERROR_COUNT           out  8         saturating count of FRAME_ERROR pulses
// BEHAVIOUR
//  Reset (RST low, async): CONTROL_REGS all = REG_RESET, REG_UPDATE=0, UPDATE_ADDR=0,
//   FRAME_ERROR=0, ERROR_COUNT=0, state=IDLE, edge register=0, timeout counter=0.
//  Byte accept: on a CLK edge where TRANSFER_IN_RECEIVED=1 and the registered copy=0.
//   The registered copy follows the input each cycle. A level held high is one byte only.
//  FSM, advancing only on accepted bytes:
//   IDLE  : H1 -> HDR1; else stay
//   HDR1  : H2 -> HDR2; H1 -> HDR1 (resync); else -> IDLE
//   HDR2  : H3 -> ADDR; H1 -> HDR1; else -> IDLE
//   ADDR  : latch addr -> DATA (any value)
//   DATA  : latch data -> CHK  (any value)
//   CHK   : byte == addr^data and addr < N_REGS: write regs[addr]=data, UPDATE_ADDR=addr,
//           REG_UPDATE=1; else FRAME_ERROR=1, no write. Both cases -> IDLE
//  Latency: write visible on CONTROL_REGS at the same edge that accepts CHK.
//   REG_UPDATE/FRAME_ERROR are high for exactly the following cycle.
//  Timeout: counter clears on each accepted byte and while IDLE. Counts otherwise.
//   On reaching TIMEOUT_CYCLES -> IDLE, FRAME_ERROR pulse, counter clears.
//   Counter width is $clog2(TIMEOUT_CYCLES+1). TIMEOUT_CYCLES=0: never times out.
//  Byte accepted on the same edge the timeout fires: the timeout wins and the byte is dropped.
//  ERROR_COUNT increments with each FRAME_ERROR pulse and saturates at 8'hFF.
//   Header mismatches are not errors.
//  Unwritten registers hold their value. No other path modifies CONTROL_REGS.
//  RST low mid-frame aborts the frame and restores all reset values immediately.
// TESTING
//  1 5A C3 7E 02 A5 A7 (N_REGS=4) -> reg2=A5, others=00, REG_UPDATE one cycle, UPDATE_ADDR=02.
//  2 5A C3 7E 01 10 00 (bad chk) -> no write, FRAME_ERROR one cycle, ERROR_COUNT=1.
//  3 5A C3 7E 07 33 34 (addr >= N_REGS) -> no write, FRAME_ERROR, ERROR_COUNT increments.
//  4 5A 5A C3 7E 00 FF FF -> resync in HDR1, reg0=FF. Strobe held high 50 cycles -> one byte only.
//  5 TIMEOUT_CYCLES=20: 5A C3 7E, then 20 idle cycles -> FRAME_ERROR, IDLE.
//    Then a full valid frame -> write succeeds.
//  6 Assert RST between DATA and CHK -> all regs=REG_RESET. Late CHK byte ignored (FSM in IDLE).
//    300 bad frames -> ERROR_COUNT saturates at FF.

Source files
------------

// File: rtl/control_register_bank.sv
// Framed control-register writer: parses H1 H2 H3 ADDR DATA CHK from the receiver byte
// stream and updates one of N_REGS 8-bit registers, reporting checksum/address/timeout errors.
module control_register_bank #(
  parameter int         N_REGS         = 4,
  parameter logic [7:0] HDR_BYTE1      = 8'h5A,
  parameter logic [7:0] HDR_BYTE2      = 8'hC3,
  parameter logic [7:0] HDR_BYTE3      = 8'h7E,
  parameter logic [7:0] REG_RESET      = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TRANSFER_IN_RECEIVED,
  input  logic [7:0]            TRANSFER_IN_BYTE,
  output logic [8*N_REGS-1:0]   CONTROL_REGS,
  output logic                  REG_UPDATE,
  output logic [7:0]            UPDATE_ADDR,
  output logic                  FRAME_ERROR,
  output logic [7:0]            ERROR_COUNT
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_HDR2, S_ADDR, S_DATA, S_CHK} state_t;

  state_t                   state_q, state_d;
  logic                     rcv_q;
  logic [7:0]               addr_q, addr_d, data_q, data_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [N_REGS-1:0][7:0]   regs_q, regs_d;
  logic                     upd_q, upd_d, err_q, err_d;
  logic [7:0]               uaddr_q, uaddr_d, ecnt_q, ecnt_d;
  logic                     accept, timeout, addr_ok;

  assign accept  = TRANSFER_IN_RECEIVED & ~rcv_q;
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q != S_IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign addr_ok = (32'(addr_q) < N_REGS);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    regs_d  = regs_q;
    uaddr_d = uaddr_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    // Timeout takes priority: a byte landing on the expiry edge is dropped.
    if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (accept) begin
      case (state_q)
        S_IDLE: if (TRANSFER_IN_BYTE == HDR_BYTE1) state_d = S_HDR1;
        S_HDR1: begin
          if (TRANSFER_IN_BYTE == HDR_BYTE2)      state_d = S_HDR2;
          else if (TRANSFER_IN_BYTE == HDR_BYTE1) state_d = S_HDR1;
          else                                    state_d = S_IDLE;
        end
        S_HDR2: begin
          if (TRANSFER_IN_BYTE == HDR_BYTE3)      state_d = S_ADDR;
          else if (TRANSFER_IN_BYTE == HDR_BYTE1) state_d = S_HDR1;
          else                                    state_d = S_IDLE;
        end
        S_ADDR: begin
          addr_d  = TRANSFER_IN_BYTE;
          state_d = S_DATA;
        end
        S_DATA: begin
          data_d  = TRANSFER_IN_BYTE;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if ((TRANSFER_IN_BYTE == (addr_q ^ data_q)) && addr_ok) begin
            for (int k = 0; k < N_REGS; k++)
              if (addr_q == 8'(k)) regs_d[k] = data_q;
            uaddr_d = addr_q;
            upd_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (TIMEOUT_CYCLES == 0 || timeout || accept || state_q == S_IDLE) cnt_d = '0;
    ecnt_d = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      rcv_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      regs_q  <= {N_REGS{REG_RESET}};
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      uaddr_q <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcv_q   <= TRANSFER_IN_RECEIVED;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      uaddr_q <= uaddr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign CONTROL_REGS = regs_q;
  assign REG_UPDATE   = upd_q;
  assign UPDATE_ADDR  = uaddr_q;
  assign FRAME_ERROR  = err_q;
  assign ERROR_COUNT  = ecnt_q;

endmodule
